// File: rtl/codec_pkg.sv
// Shared types and constants for the WM8731 codec serial paths (capture and playback).
package codec_pkg;

  localparam int   WD_DEFAULT      = 24;
  localparam logic CHAN_LEFT_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out register, MSB first; mirror of the playback PISO register.
module sipo_shift_reg import codec_pkg::*; #(
  parameter int WD = WD_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic          sdata_i,
  output logic [WD-1:0] pdata_o
);

  logic [WD-1:0] sreg_q, sreg_d;

  // A clear coinciding with a shift starts the new word with that bit.
  always_comb begin
    sreg_d = sreg_q;
    if (clr_i && shift_i) begin
      sreg_d = {{(WD-1){1'b0}}, sdata_i};
    end else if (clr_i) begin
      sreg_d = '0;
    end else if (shift_i) begin
      sreg_d = {sreg_q[WD-2:0], sdata_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign pdata_o = sreg_q;

endmodule

// File: rtl/s2p_buffer_rjm_codec.sv
// WM8731 ADC right-justified receiver: frames stereo pairs, valid/ready output.
// Define S2P_RJM_SYNC_EN to put a 2-flop synchronizer on the codec inputs.
module s2p_buffer_rjm_codec import codec_pkg::*; #(
  parameter int WD    = WD_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          codec_bclk_i,
  input  logic          codec_adclrck_i,
  input  logic          codec_adcdat_i,
  output logic [WD-1:0] left_o,
  output logic [WD-1:0] right_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overrun_o,
  output logic          short_frame_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WD_CNT  = CNT_W'(WD);

  logic bclk_q, lrck_q, dat_q;

`ifdef S2P_RJM_SYNC_EN
  logic bclk_m_q, lrck_m_q, dat_m_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_m_q <= 1'b0;
      lrck_m_q <= 1'b0;
      dat_m_q  <= 1'b0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      dat_q    <= 1'b0;
    end else begin
      bclk_m_q <= codec_bclk_i;
      lrck_m_q <= codec_adclrck_i;
      dat_m_q  <= codec_adcdat_i;
      bclk_q   <= bclk_m_q;
      lrck_q   <= lrck_m_q;
      dat_q    <= dat_m_q;
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
      dat_q  <= 1'b0;
    end else begin
      bclk_q <= codec_bclk_i;
      lrck_q <= codec_adclrck_i;
      dat_q  <= codec_adcdat_i;
    end
  end
`endif

  // Edge flags are registered; data is delayed alongside so each bit lines up with its BCLK rise.
  logic bclk_prev_q, lrck_prev_q;
  logic bclk_rise_q, lr_start_q, lr_end_q, dat_e_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      bclk_rise_q <= 1'b0;
      lr_start_q  <= 1'b0;
      lr_end_q    <= 1'b0;
      dat_e_q     <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_q;
      lrck_prev_q <= lrck_q;
      bclk_rise_q <= bclk_q & ~bclk_prev_q;
      lr_start_q  <= (lrck_q == CHAN_LEFT_LEVEL) && (lrck_prev_q != CHAN_LEFT_LEVEL);
      lr_end_q    <= (lrck_q != CHAN_LEFT_LEVEL) && (lrck_prev_q == CHAN_LEFT_LEVEL);
      dat_e_q     <= dat_q;
    end
  end

  state_e           state_q, state_d;
  logic             shift, clr, latch_left, commit, short_d;
  logic [WD-1:0]    sreg;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WD-1:0]    left_hold_q, left_q, right_q;
  logic             valid_q, overrun_q, short_q;

  assign shift = en_i & bclk_rise_q;
  assign clr   = ~en_i | lr_start_q | lr_end_q;

  sipo_shift_reg #(.WD(WD)) u_sipo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .shift_i (shift),
    .sdata_i (dat_e_q),
    .pdata_o (sreg)
  );

  always_comb begin
    state_d    = state_q;
    latch_left = 1'b0;
    commit     = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (lr_start_q) state_d = LEFT;
        LEFT:    if (lr_end_q) begin
                   latch_left = 1'b1;
                   state_d    = RIGHT;
                 end
        RIGHT:   if (lr_start_q) begin
                   commit  = 1'b1;
                   state_d = LEFT;
                 end
        default: state_d = IDLE;
      endcase
    end
  end

  // The count seen here excludes any bit shifting in on the same cycle as the edge.
  assign short_d = (latch_left | commit) && (bit_cnt_q < WD_CNT);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      bit_cnt_d = {{(CNT_W-1){1'b0}}, shift};
    end else if (shift && bit_cnt_q != CNT_MAX) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Handshake: a commit wins over an accept; overrun only when the old pair was still unaccepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      short_q   <= short_d;
      if (latch_left) begin
        left_hold_q <= sreg;
      end
      if (commit) begin
        left_q    <= left_hold_q;
        right_q   <= sreg;
        valid_q   <= 1'b1;
        overrun_q <= valid_q & ~ready_i;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign left_o        = left_q;
  assign right_o       = right_q;
  assign valid_o       = valid_q;
  assign overrun_o     = overrun_q;
  assign short_frame_o = short_q;

endmodule

// File: tb/tb_s2p_buffer_rjm_codec.sv
// Bench for s2p_buffer_rjm_codec: randomized right-justified frames against a frame-level model.
module tb_s2p_buffer_rjm_codec;
  import codec_pkg::*;

  localparam int WD = 24;
  localparam int W  = 2*WD+1;
`ifdef S2P_RJM_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0;
  logic rst, en, bclk, lrck, dat, ready;
  logic [WD-1:0] left_o, right_o;
  logic valid_o, overrun_o, short_frame_o;

  s2p_buffer_rjm_codec #(.WD(WD), .CNT_W(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .codec_bclk_i    (bclk),
    .codec_adclrck_i (lrck),
    .codec_adcdat_i  (dat),
    .left_o          (left_o),
    .right_o         (right_o),
    .valid_o         (valid_o),
    .ready_i         (ready),
    .overrun_o       (overrun_o),
    .short_frame_o   (short_frame_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ov_cnt   = 0;
  int sh_cnt   = 0;

  always @(posedge clk) begin
    if (overrun_o === 1'b1) ov_cnt++;
    if (short_frame_o === 1'b1) sh_cnt++;
  end

  // scoreboard: entries are {right_short, left_word, right_word} of frames awaiting commit
  logic [W-1:0]  exp_q[$];
  bit            m_active;
  bit            m_valid;
  bit            m_commit;
  logic [WD-1:0] m_l, m_r;
  int            exp_ov = 0;
  int            exp_sh = 0;
  logic          obs_pre, obs_post;

  function automatic logic [WD-1:0] exp_word(input logic [31:0] v, input int n);
    logic [31:0] m;
    m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return WD'(v & m);
  endfunction

  // drivers
  task automatic bit_out(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; dat = d;
    repeat (2) @(negedge clk);
    bclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic bit_out_sim(input logic lr, input logic d);
    bclk = 1'b0; dat = d;
    repeat (2) @(negedge clk);
    bclk = 1'b1; lrck = lr;
    repeat (2) @(negedge clk);
  endtask

  task automatic lr_rise(input logic d, input bit acc);
    bclk = 1'b0; lrck = 1'b1; dat = d;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 2) bclk = 1'b1;
      if (n == S+1) begin
        obs_pre = valid_o;
        if (acc) ready = 1'b1;
      end
      if (n == S+2) begin
        obs_post = valid_o;
        ready = 1'b0;
      end
    end
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] lv, input int ln, input logic [31:0] rv,
                            input int rn, input bit acc, input bit sim);
    logic [W-1:0] e;
    logic sr;
    lr_rise(lv[ln-1], acc);
    m_commit = 1'b0;
    if (en) begin
      if (!m_active) begin
        m_active = 1'b1;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_commit = 1'b1;
        if (m_valid && !acc) exp_ov++;
        if (e[W-1]) exp_sh++;
        m_l = e[2*WD-1:WD];
        m_r = e[WD-1:0];
        m_valid = 1'b1;
      end
    end
    if (acc && !m_commit) m_valid = 1'b0;
    for (int i = ln-2; i >= 0; i--) bit_out(1'b1, lv[i]);
    if (sim) bit_out_sim(1'b0, rv[rn-1]);
    else     bit_out(1'b0, rv[rn-1]);
    for (int i = rn-2; i >= 0; i--) bit_out(1'b0, rv[i]);
    if (en && m_active) begin
      if (ln < WD) exp_sh++;
      sr = (rn < WD);
      exp_q.push_back({sr, exp_word(lv, ln), exp_word(rv, rn)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
    m_active = 1'b0; m_valid = 1'b0; m_l = '0; m_r = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (left_o !== '0) $display("FAIL reset_left: got %h want 0", left_o); else n_pass++;
    n_checks++; if (right_o !== '0) $display("FAIL reset_right: got %h want 0", right_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
    n_checks++; if (overrun_o !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun_o); else n_pass++;
    n_checks++; if (short_frame_o !== 1'b0) $display("FAIL reset_short: got %b want 0", short_frame_o); else n_pass++;
  endtask

  task automatic test_basic();
    en = 1'b1;
    @(negedge clk);
    send_frame(32'h00A5_F00F, 32, 32'h0012_3456, 32, 1'b0, 1'b0);
    n_checks++; if (valid_o !== 1'b0) $display("FAIL basic_first_frame_valid: got %b want 0", valid_o); else n_pass++;
    send_frame(32'h00A5_F00F, 32, 32'h0012_3456, 32, 1'b0, 1'b0);
    n_checks++; if (obs_pre !== 1'b0) $display("FAIL basic_latency_early: got %b want 0", obs_pre); else n_pass++;
    n_checks++; if (obs_post !== 1'b1) $display("FAIL basic_latency_valid: got %b want 1", obs_post); else n_pass++;
    n_checks++; if (left_o !== 24'hA5F00F) $display("FAIL basic_left: got %h want a5f00f", left_o); else n_pass++;
    n_checks++; if (right_o !== 24'h123456) $display("FAIL basic_right: got %h want 123456", right_o); else n_pass++;
    n_checks++; if (sh_cnt !== exp_sh) $display("FAIL basic_short_count: got %0d want %0d", sh_cnt, exp_sh); else n_pass++;
    accept();
    n_checks++; if (valid_o !== 1'b0) $display("FAIL basic_accept_valid: got %b want 0", valid_o); else n_pass++;
  endtask

  task automatic test_overrun();
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (obs_pre !== 1'b1) $display("FAIL overrun_pending: got %b want 1", obs_pre); else n_pass++;
    n_checks++; if (valid_o !== m_valid) $display("FAIL overrun_valid: got %b want %b", valid_o, m_valid); else n_pass++;
    n_checks++; if (left_o !== m_l) $display("FAIL overrun_left: got %h want %h", left_o, m_l); else n_pass++;
    n_checks++; if (right_o !== m_r) $display("FAIL overrun_right: got %h want %h", right_o, m_r); else n_pass++;
    n_checks++; if (ov_cnt !== exp_ov) $display("FAIL overrun_count: got %0d want %0d", ov_cnt, exp_ov); else n_pass++;
  endtask

  task automatic test_commit_accept();
    send_frame($urandom, 32, $urandom, 32, 1'b1, 1'b0);
    n_checks++; if (obs_post !== 1'b1) $display("FAIL ca_valid_at_commit: got %b want 1", obs_post); else n_pass++;
    n_checks++; if (valid_o !== 1'b1) $display("FAIL ca_valid: got %b want 1", valid_o); else n_pass++;
    n_checks++; if (left_o !== m_l) $display("FAIL ca_left: got %h want %h", left_o, m_l); else n_pass++;
    n_checks++; if (right_o !== m_r) $display("FAIL ca_right: got %h want %h", right_o, m_r); else n_pass++;
    n_checks++; if (ov_cnt !== exp_ov) $display("FAIL ca_overrun_count: got %0d want %0d", ov_cnt, exp_ov); else n_pass++;
  endtask

  task automatic test_short();
    accept();
    send_frame(32'h000F_FFFF, 20, $urandom, 32, 1'b0, 1'b0);
    accept();
    send_frame($urandom, 32, $urandom, 16, 1'b0, 1'b0);
    n_checks++; if (left_o !== 24'h0FFFFF) $display("FAIL short_left: got %h want 0fffff", left_o); else n_pass++;
    n_checks++; if (right_o !== m_r) $display("FAIL short_right: got %h want %h", right_o, m_r); else n_pass++;
    n_checks++; if (sh_cnt !== exp_sh) $display("FAIL short_count_left: got %0d want %0d", sh_cnt, exp_sh); else n_pass++;
    accept();
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (right_o !== m_r) $display("FAIL short_right16: got %h want %h", right_o, m_r); else n_pass++;
    n_checks++; if (sh_cnt !== exp_sh) $display("FAIL short_count_right: got %0d want %0d", sh_cnt, exp_sh); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] rv;
    rv = $urandom | 32'h0080_0000;
    accept();
    send_frame($urandom, 24, rv, 24, 1'b0, 1'b1);
    accept();
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (left_o !== m_l) $display("FAIL sim_left: got %h want %h", left_o, m_l); else n_pass++;
    n_checks++; if (right_o !== m_r) $display("FAIL sim_right: got %h want %h", right_o, m_r); else n_pass++;
    n_checks++; if (sh_cnt !== exp_sh) $display("FAIL sim_short_count: got %0d want %0d", sh_cnt, exp_sh); else n_pass++;
  endtask

  task automatic test_reset_mid();
    accept();
    send_frame($urandom, 32, $urandom, 12, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_active = 1'b0; m_valid = 1'b0; m_l = '0; m_r = '0;
    @(negedge clk);
    n_checks++; if (left_o !== '0) $display("FAIL rstmid_left: got %h want 0", left_o); else n_pass++;
    n_checks++; if (right_o !== '0) $display("FAIL rstmid_right: got %h want 0", right_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", valid_o); else n_pass++;
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (valid_o !== 1'b0) $display("FAIL rstmid_no_early_valid: got %b want 0", valid_o); else n_pass++;
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (valid_o !== 1'b1) $display("FAIL rstmid_valid_after_frame: got %b want 1", valid_o); else n_pass++;
    n_checks++; if (left_o !== m_l) $display("FAIL rstmid_new_left: got %h want %h", left_o, m_l); else n_pass++;
    n_checks++; if (right_o !== m_r) $display("FAIL rstmid_new_right: got %h want %h", right_o, m_r); else n_pass++;
    n_checks++; if (sh_cnt !== exp_sh) $display("FAIL rstmid_short_count: got %0d want %0d", sh_cnt, exp_sh); else n_pass++;
  endtask

  task automatic test_enable();
    en = 1'b0;
    m_active = 1'b0;
    exp_q.delete();
    @(negedge clk);
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (valid_o !== 1'b1) $display("FAIL en_hold_valid: got %b want 1", valid_o); else n_pass++;
    n_checks++; if (left_o !== m_l) $display("FAIL en_hold_left: got %h want %h", left_o, m_l); else n_pass++;
    n_checks++; if (right_o !== m_r) $display("FAIL en_hold_right: got %h want %h", right_o, m_r); else n_pass++;
    en = 1'b1;
    @(negedge clk);
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (left_o !== m_l) $display("FAIL en_resume_idle_left: got %h want %h", left_o, m_l); else n_pass++;
    accept();
    send_frame($urandom, 32, $urandom, 32, 1'b0, 1'b0);
    n_checks++; if (valid_o !== 1'b1) $display("FAIL en_resume_valid: got %b want 1", valid_o); else n_pass++;
    n_checks++; if (left_o !== m_l) $display("FAIL en_resume_left: got %h want %h", left_o, m_l); else n_pass++;
    n_checks++; if (right_o !== m_r) $display("FAIL en_resume_right: got %h want %h", right_o, m_r); else n_pass++;
    n_checks++; if (ov_cnt !== exp_ov) $display("FAIL en_overrun_count: got %0d want %0d", ov_cnt, exp_ov); else n_pass++;
  endtask

  task automatic test_random();
    int ln, rn;
    bit acc;
    for (int it = 0; it < 8; it++) begin
      ln  = $urandom_range(16, 32);
      rn  = $urandom_range(16, 32);
      acc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) accept();
      send_frame($urandom, ln, $urandom, rn, acc, 1'b0);
      if (m_commit) begin
        n_checks++; if (valid_o !== m_valid) $display("FAIL rand_valid it%0d: got %b want %b", it, valid_o, m_valid); else n_pass++;
        n_checks++; if (left_o !== m_l) $display("FAIL rand_left it%0d: got %h want %h", it, left_o, m_l); else n_pass++;
        n_checks++; if (right_o !== m_r) $display("FAIL rand_right it%0d: got %h want %h", it, right_o, m_r); else n_pass++;
      end
    end
    n_checks++; if (ov_cnt !== exp_ov) $display("FAIL rand_overrun_count: got %0d want %0d", ov_cnt, exp_ov); else n_pass++;
    n_checks++; if (sh_cnt !== exp_sh) $display("FAIL rand_short_count: got %0d want %0d", sh_cnt, exp_sh); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_commit_accept();
    test_short();
    test_simultaneous();
    test_reset_mid();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
